// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream program loader for the instruction memory
module imem_boot_loader #(
    parameter int DEPTH = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W   = $clog2(DEPTH + 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_LOAD = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [23:0]      byte_sr;
    logic [IDX_W-1:0] word_index;
    logic [IDX_W-1:0] prog_len;
    logic [31:0]      acc;

    // The three leading bytes of a word plus the byte on the bus form the
    // completed big-endian word; first byte received ends up in [31:24].
    logic [31:0] cur_word;
    logic        take;
    logic        word_done;

    assign cur_word  = {byte_sr, in_data};
    assign take      = in_valid && in_ready;
    assign word_done = take && (byte_cnt == 2'd3);

    // Status outputs are decoded straight from the state register so they
    // settle one cycle after each transition.
    assign in_ready = (state == S_LEN) || (state == S_LOAD) || (state == S_CHK);
    assign busy     = in_ready;
    assign cpu_hold = in_ready || (state == S_ERR);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);

    // Loader FSM: byte assembly, header/length check, memory writes, checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            byte_cnt    <= 2'd0;
            byte_sr     <= 24'd0;
            word_index  <= '0;
            prog_len    <= '0;
            acc         <= 32'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= 32'd0;
            mem_wr_data <= 32'd0;
        end else begin
            mem_wr_en <= 1'b0;

            // Byte lane counter and shift register advance on every accepted byte.
            if (take) begin
                byte_sr  <= cur_word[23:0];
                byte_cnt <= byte_cnt + 2'd1;
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        byte_cnt   <= 2'd0;
                        word_index <= '0;
                        acc        <= 32'd0;
                    end
                end

                S_LEN: begin
                    if (word_done) begin
                        if ((cur_word == 32'd0) || (cur_word > DEPTH_W)) begin
                            state <= S_ERR;
                        end else begin
                            prog_len <= cur_word[IDX_W-1:0];
                            state    <= S_LOAD;
                        end
                    end
                end

                S_LOAD: begin
                    if (word_done) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= cur_word;
                        mem_wr_addr <= 32'(word_index) << 2;
                        acc         <= acc ^ cur_word;
                        word_index  <= word_index + 1'b1;
                        if ((word_index + 1'b1) == prog_len) begin
                            state <= S_CHK;
                        end
                    end
                end

                S_CHK: begin
                    if (word_done) begin
                        state <= (cur_word == acc) ? S_DONE : S_ERR;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int pulse_viol = 0;
    logic prev_wr_en = 1'b0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_boot_loader #(.DEPTH(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and flag strobes longer than one cycle.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_wr_addr);
            wr_data_q.push_back(mem_wr_data);
            if (prev_wr_en) pulse_viol++;
        end
        prev_wr_en = mem_wr_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_good_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            chk({tag, "_a0"}, wr_addr_q[0], 32'h0000_0000);
            chk({tag, "_d0"}, wr_data_q[0], 32'h2008_0005);
            chk({tag, "_a1"}, wr_addr_q[1], 32'h0000_0004);
            chk({tag, "_d1"}, wr_data_q[1], 32'h2009_000A);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en",    32'(mem_wr_en), 32'd0);
        chk("rst_addr",     mem_wr_addr, 32'd0);
        chk("rst_data",     mem_wr_data, 32'd0);
        chk("rst_hold",     32'(cpu_hold), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_error",    32'(error), 32'd0);

        // Bytes offered in IDLE are not taken
        in_data = 8'hAA; in_valid = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("idle_ready2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Good load
        clear_log();
        pulse_start();
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_hold",  32'(cpu_hold), 32'd1);
        chk("start_busy",  32'(busy), 32'd1);
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h2009_000A, 1'b0);
        send_word(32'h0001_000F, 1'b0);
        chk("good_done",  32'(done), 32'd1);
        chk("good_error", 32'(error), 32'd0);
        chk("good_hold",  32'(cpu_hold), 32'd0);
        chk("good_busy",  32'(busy), 32'd0);
        chk("good_ready", 32'(in_ready), 32'd0);
        check_good_writes("good");

        // Bad checksum
        clear_log();
        pulse_start();
        chk("restart_done_clr", 32'(done), 32'd0);
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h2009_000A, 1'b0);
        send_word(32'h0001_000E, 1'b0);
        chk("bchk_error", 32'(error), 32'd1);
        chk("bchk_done",  32'(done), 32'd0);
        chk("bchk_hold",  32'(cpu_hold), 32'd1);
        check_good_writes("bchk");

        // Bad length: zero
        clear_log();
        pulse_start();
        chk("blen0_err_clr", 32'(error), 32'd0);
        send_word(32'h0000_0000, 1'b0);
        chk("blen0_error", 32'(error), 32'd1);
        chk("blen0_ready", 32'(in_ready), 32'd0);
        chk("blen0_hold",  32'(cpu_hold), 32'd1);
        @(negedge clk);
        chk("blen0_nwr", 32'(wr_addr_q.size()), 32'd0);

        // Bad length: DEPTH+1
        pulse_start();
        send_word(32'h0000_0065, 1'b0);
        chk("blen101_error", 32'(error), 32'd1);
        chk("blen101_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("blen101_nwr", 32'(wr_addr_q.size()), 32'd0);

        // Length exactly DEPTH is accepted (still loading afterwards)
        pulse_start();
        send_word(32'h0000_0064, 1'b0);
        chk("len100_busy",  32'(busy), 32'd1);
        chk("len100_error", 32'(error), 32'd0);

        // Reset mid-load after 6 payload bytes
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        clear_log();
        pulse_start();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h09, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ready", 32'(in_ready), 32'd0);
        chk("mrst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("mrst_addr",  mem_wr_addr, 32'd0);
        chk("mrst_data",  mem_wr_data, 32'd0);
        chk("mrst_hold",  32'(cpu_hold), 32'd0);
        chk("mrst_busy",  32'(busy), 32'd0);
        chk("mrst_done",  32'(done), 32'd0);
        chk("mrst_error", 32'(error), 32'd0);
        in_data = 8'h00; in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("mrst_nwr", 32'(wr_addr_q.size()), 32'd1);

        // Full good load after the reset
        clear_log();
        pulse_start();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h2009_000A, 1'b0);
        send_word(32'h0001_000F, 1'b0);
        chk("post_rst_done", 32'(done), 32'd1);
        check_good_writes("post_rst");

        // Handshake gaps: in_valid toggled every other cycle
        clear_log();
        pulse_start();
        send_word(32'h0000_0002, 1'b1);
        send_word(32'h2008_0005, 1'b1);
        send_word(32'h2009_000A, 1'b1);
        send_word(32'h0001_000F, 1'b0);
        chk("gap_done",  32'(done), 32'd1);
        chk("gap_error", 32'(error), 32'd0);
        check_good_writes("gap");

        // start during LOAD is ignored; start in DONE restarts
        clear_log();
        pulse_start();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        pulse_start();
        chk("ldstart_busy", 32'(busy), 32'd1);
        send_word(32'h2009_000A, 1'b0);
        send_word(32'h0001_000F, 1'b0);
        chk("ldstart_done", 32'(done), 32'd1);
        check_good_writes("ldstart");

        clear_log();
        pulse_start();
        chk("dstart_done",  32'(done), 32'd0);
        chk("dstart_ready", 32'(in_ready), 32'd1);
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'h2009_000A, 1'b0);
        send_word(32'h0001_000F, 1'b0);
        chk("dstart_done2", 32'(done), 32'd1);
        check_good_writes("dstart");

        chk("wr_pulse_width", 32'(pulse_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Write-side companion to the instruction memory: receives a program image as a byte stream over a valid/ready handshake and writes it into instruction memory, one 32-bit word at a time. It assembles big-endian words, checks a length header and an XOR checksum, and holds the CPU while a load is in progress. It sits between a byte source, such as a UART receiver, and the instruction memory write port.

## Interface
- DEPTH, 100, instruction memory depth in 32-bit words; legal program length is 1..DEPTH.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; acted on only in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_wr_en  output  1  one-cycle instruction memory write strobe.
- mem_wr_addr  output  32  byte address, word-aligned, equal to word_index << 2.
- mem_wr_data  output  32  instruction word.
- cpu_hold  output  1  keeps the CPU stalled or in reset while it is high.
- busy  output  1  a load is in progress (LEN, LOAD or CHK).
- done  output  1  last load completed with a good checksum.
- error  output  1  last load failed on length or checksum.

## Operation
- Stream format: 4-byte length N, then N payload words, then a 4-byte checksum. Every word is big-endian; the first byte goes to bits [31:24].
- The checksum is the XOR of all N payload words.
- A byte is consumed only on a cycle where in_valid and in_ready are both 1. in_valid while in_ready=0 is ignored, and the source holds the byte.
- A 2-bit byte counter selects the byte lane. A word completes on the 4th consumed byte, and the counter then wraps to 0.
- IDLE: in_ready=0, cpu_hold=0. start -> LEN, which clears the byte counter, word_index, the checksum accumulator, done and error.
- LEN: in_ready=1. On word completion:
  - N==0 or N>DEPTH -> ERR.
  - Otherwise latch N and go to LOAD.
- LOAD: in_ready=1. On each word completion:
  - Register the word to mem_wr_data, set mem_wr_addr = word_index<<2 and mem_wr_en=1.
  - XOR the word into the accumulator and increment word_index.
  - On the Nth word -> CHK.
- CHK: in_ready=1. On word completion, received == accumulator -> DONE, otherwise -> ERR.
- DONE: done=1, in_ready=0, cpu_hold=0.
- ERR: error=1, in_ready=0, cpu_hold=1, so a corrupt image never runs.
- DONE and ERR hold until start (restart into LEN) or rst.
- start in LEN, LOAD or CHK is ignored.
- Arithmetic: word_index is $clog2(DEPTH+1) bits wide, zero-extended and shifted left by 2 to form mem_wr_addr. The 32-bit length compare is unsigned.

## Timing
- Reset values: in_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, cpu_hold=0, busy=0, done=0, error=0. State = IDLE, all counters 0.
- in_ready, busy and cpu_hold are decoded from registered state, so they change the cycle after a transition.
- start -> in_ready=1 and cpu_hold=1 on the next cycle.
- Write latency: mem_wr_en is high for exactly 1 cycle, in the cycle after the 4th byte of a payload word is consumed. Address and data are valid in that same cycle.
- Throughput: one byte per cycle, so one write per 4 cycles minimum. Gaps in in_valid stretch the timing without changing the result.
- The final payload write and the CHK transition happen together, so a checksum byte may be consumed in the same cycle the last write is strobed.
- done or error goes high the cycle after the 4th checksum byte, or after the 4th length byte for a length error.
- rst mid-load: IDLE on the next cycle and all outputs at reset values. A completed-word write that has not yet been strobed is dropped. Words already written stay in memory.
- rst has priority over start.

## Test plan
- Good load, DEPTH=100. After start, send bytes 00 00 00 02, 20 08 00 05, 20 09 00 0A, 00 01 00 0F.
  - Required: exactly two writes, (addr 0x0, 0x20080005) then (addr 0x4, 0x2009000A).
  - Then done=1, error=0, cpu_hold=0, busy=0.
- Bad checksum: the same stream with a final word of 00 01 00 0E.
  - Required: the same two writes, then error=1, done=0, cpu_hold=1.
- Bad length: header 00 00 00 00, and separately 00 00 00 65 (101).
  - Required: error=1 after the 4th byte, no mem_wr_en, in_ready=0.
- Handshake: the good-load stream with in_valid toggled every other cycle.
  - Required: identical writes and done=1.
  - Bytes presented in IDLE before start are not consumed (in_ready=0).
- Reset mid-load: assert rst after 6 payload-phase bytes.
  - Required: all outputs 0 on the next cycle and no further writes.
  - A following start plus the full good stream then succeeds.
- start pulsed during LOAD has no effect on the result. start in DONE clears done and restarts; a second good stream rewrites addresses 0x0 and 0x4.
